// File: rtl/sram_pkg.sv
// Shared constants and range-check helper for the SRAM responder.
package sram_pkg;

  localparam logic [31:0] SRAM_BASE_DEFAULT = 32'h1C00_0000;
  localparam int          SRAM_OOR_CNT_W    = 16;

  // Offset wraps modulo 2^32, so addresses below base land far out of range.
  function automatic logic sram_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          idx_w);
    logic [31:0] offset;
    offset = addr - base;
    if (idx_w >= 30) return 1'b1;
    return (offset >> (idx_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Core-side instruction and data SRAM request ports bundled as one interface.
interface sram_responder_if;

  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );

endinterface

// File: rtl/sram_bank.sv
// Word array split into byte lanes: one byte-masked write port, two registered
// read ports that return old data when they collide with the write.
module sram_bank #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             ra_en,
  input  logic [IDX_W-1:0] ra_idx,
  output logic [31:0]      ra_data,
  input  logic             rb_en,
  input  logic [IDX_W-1:0] rb_idx,
  output logic [31:0]      rb_data
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [0:(1 << IDX_W) - 1];
    logic [7:0] ra_q_reg;
    logic [7:0] rb_q_reg;

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) mem[wr_idx] <= wr_data[8*gi +: 8];
      if (ra_en) ra_q_reg <= mem[ra_idx];
      if (rb_en) rb_q_reg <= mem[rb_idx];
    end

    assign ra_data[8*gi +: 8] = ra_q_reg;
    assign rb_data[8*gi +: 8] = rb_q_reg;
  end

endmodule

// File: rtl/sram_responder.sv
// One-cycle-latency SRAM responder for the core's inst/data ports.
// Define SRAM_OOR_DIAG_EN to build the sticky out-of-range diagnostics.
module sram_responder
  import sram_pkg::*;
#(
  parameter int          IDX_W     = 16,
  parameter logic [31:0] BASE_ADDR = SRAM_BASE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  sram_responder_if.slave           bus,
  output logic                      oor_err,
  output logic [31:0]               oor_addr,
  output logic [SRAM_OOR_CNT_W-1:0] oor_cnt
);

  logic [31:0]      inst_off;
  logic [31:0]      data_off;
  logic             inst_ok;
  logic             data_ok;
  logic             inst_req;
  logic             data_req;
  logic             data_wr;
  logic             data_rd;
  logic [31:0]      inst_q;
  logic [31:0]      data_q;
  logic             inst_zero_reg;
  logic             data_zero_reg;
  logic             unused_bits;

  assign inst_off = bus.inst_sram_addr - BASE_ADDR;
  assign data_off = bus.data_sram_addr - BASE_ADDR;
  assign inst_ok  = sram_in_range(bus.inst_sram_addr, BASE_ADDR, IDX_W);
  assign data_ok  = sram_in_range(bus.data_sram_addr, BASE_ADDR, IDX_W);

  // Requests presented while reset is high are discarded, writes included.
  assign inst_req = bus.inst_sram_en && !reset;
  assign data_req = bus.data_sram_en && !reset;
  assign data_wr  = data_req && (bus.data_sram_we != 4'h0);
  assign data_rd  = data_req && (bus.data_sram_we == 4'h0);

  sram_bank #(.IDX_W(IDX_W)) u_bank (
    .clk     (clk),
    .wr_en   (data_wr && data_ok),
    .wr_be   (bus.data_sram_we),
    .wr_idx  (data_off[IDX_W+1:2]),
    .wr_data (bus.data_sram_wdata),
    .ra_en   (inst_req && inst_ok),
    .ra_idx  (inst_off[IDX_W+1:2]),
    .ra_data (inst_q),
    .rb_en   (data_rd && data_ok),
    .rb_idx  (data_off[IDX_W+1:2]),
    .rb_data (data_q)
  );

  // Bank read registers carry no reset; these flags mask them to zero after
  // reset and after an out-of-range read, and hold while the port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_zero_reg <= 1'b1;
      data_zero_reg <= 1'b1;
    end else begin
      if (inst_req) inst_zero_reg <= !inst_ok;
      if (data_rd)  data_zero_reg <= !data_ok;
    end
  end

  assign bus.inst_sram_rdata = inst_zero_reg ? 32'h0 : inst_q;
  assign bus.data_sram_rdata = data_zero_reg ? 32'h0 : data_q;

`ifdef SRAM_OOR_DIAG_EN
  logic                      inst_oor;
  logic                      data_oor;
  logic                      oor_err_reg;
  logic [31:0]               oor_addr_reg;
  logic [SRAM_OOR_CNT_W-1:0] oor_cnt_reg;
  logic [SRAM_OOR_CNT_W:0]   cnt_sum;
  logic [SRAM_OOR_CNT_W-1:0] oor_cnt_next;

  assign inst_oor     = inst_req && !inst_ok;
  assign data_oor     = data_req && !data_ok;
  assign cnt_sum      = {1'b0, oor_cnt_reg}
                      + (SRAM_OOR_CNT_W + 1)'(inst_oor)
                      + (SRAM_OOR_CNT_W + 1)'(data_oor);
  assign oor_cnt_next = cnt_sum[SRAM_OOR_CNT_W] ? '1 : cnt_sum[SRAM_OOR_CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      oor_err_reg  <= 1'b0;
      oor_addr_reg <= 32'h0;
      oor_cnt_reg  <= '0;
    end else begin
      if (inst_oor || data_oor) oor_err_reg <= 1'b1;
      // Only the first offender is kept; the data port wins a tie.
      if (!oor_err_reg && (inst_oor || data_oor))
        oor_addr_reg <= data_oor ? bus.data_sram_addr : bus.inst_sram_addr;
      oor_cnt_reg <= oor_cnt_next;
    end
  end

  assign oor_err  = oor_err_reg;
  assign oor_addr = oor_addr_reg;
  assign oor_cnt  = oor_cnt_reg;
`else
  assign oor_err  = 1'b0;
  assign oor_addr = 32'h0;
  assign oor_cnt  = '0;
`endif

  assign unused_bits = ^{bus.inst_sram_we, bus.inst_sram_wdata,
                         inst_off[1:0], inst_off[31:IDX_W+2],
                         data_off[1:0], data_off[31:IDX_W+2]};

endmodule

// File: tb/tb_sram_responder.sv
// Directed scoreboard bench for sram_responder; diagnostic expectations
// follow the SRAM_OOR_DIAG_EN build option.
module tb_sram_responder;

  logic        clk;
  logic        reset;
  logic        oor_err;
  logic [31:0] oor_addr;
  logic [15:0] oor_cnt;
  int          cyc;
  int          n_vec;
  int          n_miss;

  sram_responder_if sif ();

  sram_responder u_dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (sif.slave),
    .oor_err  (oor_err),
    .oor_addr (oor_addr),
    .oor_cnt  (oor_cnt)
  );

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_value(input int sig);
    case (sig)
      0:       return sif.inst_sram_rdata;
      1:       return sif.data_sram_rdata;
      2:       return {31'b0, oor_err};
      3:       return oor_addr;
      default: return {16'b0, oor_cnt};
    endcase
  endfunction

  // Monitor: outputs are settled mid-cycle; retire every expectation due now.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e   = exp_q.pop_front();
      act = dut_value(e.sig);
      n_vec++;
      if (act !== e.exp) begin
        n_miss++;
        $display("FAIL %s @cyc %0d: got %h, expected %h", e.name, cyc, act, e.exp);
      end else begin
        $display("ok   %s @cyc %0d: %h", e.name, cyc, act);
      end
    end
  end

  task automatic push(input int sig, input logic [31:0] v, input string name);
    exp_q.push_back('{cyc + 1, sig, v, name});
  endtask

  task automatic push_diag(input logic e, input logic [31:0] a, input logic [15:0] c,
                           input string tag);
`ifdef SRAM_OOR_DIAG_EN
    push(2, {31'b0, e}, {tag, ".oor_err"});
    push(3, a, {tag, ".oor_addr"});
    push(4, {16'b0, c}, {tag, ".oor_cnt"});
`else
    push(2, 32'h0, {tag, ".oor_err"});
    push(3, 32'h0, {tag, ".oor_addr"});
    push(4, 32'h0, {tag, ".oor_cnt"});
`endif
  endtask

  task automatic drive(input logic ie, input logic [31:0] ia,
                       input logic de, input logic [3:0] dwe,
                       input logic [31:0] da, input logic [31:0] dw);
    sif.inst_sram_en    = ie;
    sif.inst_sram_we    = 4'h0;
    sif.inst_sram_addr  = ia;
    sif.inst_sram_wdata = 32'h0;
    sif.data_sram_en    = de;
    sif.data_sram_we    = dwe;
    sif.data_sram_addr  = da;
    sif.data_sram_wdata = dw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    push(0, 32'h0, "reset.inst_rdata");
    push(1, 32'h0, "reset.data_rdata");
    push_diag(1'b0, 32'h0, 16'h0, "reset");
    step();
    reset = 1'b0;

    // Stores then loads
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h1C00_0000, 32'hA5A5_A5A5);
    push(1, 32'h0, "store_no_rdata_update");
    step();
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h1C00_0010, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h1C00_0010, 32'h0);
    push(1, 32'hDEAD_BEEF, "load_after_store");
    step();
    drive(1'b1, 32'h1C00_0000, 1'b0, 4'h0, 32'h0, 32'h0);
    push(0, 32'hA5A5_A5A5, "fetch_word0");
    push(1, 32'hDEAD_BEEF, "data_hold_idle");
    step();

    // Byte lanes
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h1C00_0014, 32'h1122_3344);
    step();
    drive(1'b0, 32'h0, 1'b1, 4'b0100, 32'h1C00_0014, 32'h00AA_0000);
    step();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h1C00_0014, 32'h0);
    push(1, 32'h11AA_3344, "lane2_write");
    step();
    drive(1'b0, 32'h0, 1'b1, 4'b1001, 32'h1C00_0014, 32'hBB00_00CC);
    step();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h1C00_0017, 32'h0);
    push(1, 32'hBBAA_33CC, "lane0_3_write_unaligned_read");
    step();

    // Fetch/write collision returns old data
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h1C00_0020, 32'h0);
    step();
    drive(1'b1, 32'h1C00_0020, 1'b1, 4'hF, 32'h1C00_0020, 32'h5555_5555);
    push(0, 32'h0, "collision_old_data");
    step();
    drive(1'b1, 32'h1C00_0020, 1'b0, 4'h0, 32'h0, 32'h0);
    sif.inst_sram_we    = 4'hF;
    sif.inst_sram_wdata = 32'hFFFF_FFFF;
    push(0, 32'h5555_5555, "fetch_after_collision");
    step();
    drive(1'b1, 32'h1C00_0020, 1'b0, 4'h0, 32'h0, 32'h0);
    push(0, 32'h5555_5555, "inst_we_ignored");
    step();

    // Last word of the window
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h1C03_FFFC, 32'h0BAD_F00D);
    step();
    drive(1'b1, 32'h1C03_FFFE, 1'b1, 4'h0, 32'h1C03_FFFC, 32'h0);
    push(0, 32'h0BAD_F00D, "top_word_fetch");
    push(1, 32'h0BAD_F00D, "top_word_load");
    push_diag(1'b0, 32'h0, 16'h0, "top_in_range");
    step();

    // Out of range accesses
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
    push(1, 32'h0, "oor_read_zero");
    push_diag(1'b1, 32'h0000_0100, 16'd1, "oor_read");
    step();
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'hFFFF_FFF0, 32'hCAFE_F00D);
    push_diag(1'b1, 32'h0000_0100, 16'd2, "oor_write");
    step();
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h1C04_0000, 32'hCAFE_F00D);
    push_diag(1'b1, 32'h0000_0100, 16'd3, "oor_write_past_top");
    step();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h1C00_0000, 32'h0);
    push(1, 32'hA5A5_A5A5, "oor_write_dropped");
    step();
    drive(1'b1, 32'h0000_0000, 1'b0, 4'h0, 32'h0, 32'h0);
    push(0, 32'h0, "oor_fetch_zero");
    push_diag(1'b1, 32'h0000_0100, 16'd4, "oor_fetch");
    step();

    // Reset coinciding with a write
    reset = 1'b1;
    drive(1'b1, 32'h1C00_0010, 1'b1, 4'hF, 32'h1C00_0000, 32'h1234_5678);
    push(0, 32'h0, "midreset.inst_rdata");
    push(1, 32'h0, "midreset.data_rdata");
    push_diag(1'b0, 32'h0, 16'h0, "midreset");
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h1C00_0000, 32'h0);
    push(1, 32'hA5A5_A5A5, "write_in_reset_dropped");
    step();

    // Dual out of range: data address wins, count steps by 2
    drive(1'b1, 32'h0000_0400, 1'b1, 4'h0, 32'h0000_0500, 32'h0);
    push(0, 32'h0, "dual_oor.inst_rdata");
    push(1, 32'h0, "dual_oor.data_rdata");
    push_diag(1'b1, 32'h0000_0500, 16'd2, "dual_oor");
    step();

`ifdef SRAM_OOR_DIAG_EN
    for (int i = 0; i < 32766; i++) begin
      drive(1'b1, 32'h0000_0400, 1'b1, 4'hF, 32'h0000_0600, 32'h0);
      if (i == 32765) push_diag(1'b1, 32'h0000_0500, 16'hFFFE, "near_sat");
      step();
    end
    drive(1'b1, 32'h0000_0400, 1'b1, 4'hF, 32'h0000_0600, 32'h0);
    push_diag(1'b1, 32'h0000_0500, 16'hFFFF, "saturate");
    step();
    drive(1'b1, 32'h0000_0400, 1'b1, 4'hF, 32'h0000_0600, 32'h0);
    push_diag(1'b1, 32'h0000_0500, 16'hFFFF, "stay_saturated");
    step();
`endif

    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synchronous memory responder at the far end of the core's `inst_sram_*` / `data_sram_*` request ports. It holds one shared word array, services instruction fetches and data loads/stores with fixed one-cycle read latency and per-byte write enables, and returns read data in the cycle the pipeline expects it. It sits beside `mycpu_top` in the SoC/testbench wrapper. It also keeps sticky diagnostics for accesses outside its mapped window.

## Interface
- `IDX_W`, 16: word-index width; the array has 2^IDX_W 32-bit words.
- `BASE_ADDR`, 32'h1C00_0000: byte address of word 0.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `inst_sram_en` input 1: fetch request valid.
- `inst_sram_we` input 4: byte write enables on the instruction port. Always ignored; the port is read-only.
- `inst_sram_addr` input 32: fetch byte address.
- `inst_sram_wdata` input 32: ignored.
- `inst_sram_rdata` output 32: fetch data, valid the cycle after the request.
- `data_sram_en` input 1: data request valid.
- `data_sram_we` input 4: byte-lane write enables. 0 means a read.
- `data_sram_addr` input 32: data byte address.
- `data_sram_wdata` input 32: store data, already lane-aligned by the core.
- `data_sram_rdata` output 32: load data, valid the cycle after the request.
- `oor_err` output 1: sticky flag; set by any out-of-range access.
- `oor_addr` output 32: address of the first out-of-range access since reset.
- `oor_cnt` output 16: count of out-of-range accesses, saturating.

## Operation
- Offset = `addr - BASE_ADDR`, a 32-bit modulo subtraction.
- An access is in range when offset < 4·2^IDX_W; an address below BASE wraps to a large offset and is out of range.
- Word index = offset[IDX_W+1:2]. Address bits [1:0] are ignored. No alignment checking; alignment is the core's job.
- Data write: `data_sram_en` and `we`≠0 and in range. Lane i takes `wdata[8i+7:8i]` when `we[i]`=1; other lanes keep their contents.
- Data read: `data_sram_en` and `we`=0. The word is registered into `data_sram_rdata`.
- Stores do not update `data_sram_rdata`; it holds its previous value.
- Fetch: `inst_sram_en`. The word is registered into `inst_sram_rdata`.
- Out of range:
  - A read returns 32'h0 on the next cycle.
  - A write is dropped.
  - The access increments `oor_cnt`.
- Port with `en`=0: its rdata register holds its value.
- Collisions (same word, same cycle):
  - A fetch alongside a data write returns OLD data.
  - A data read and a data write cannot coincide; the data port is single-request.
- Both ports out of range in the same cycle:
  - `oor_cnt` increments by 2, still saturating at 16'hFFFF.
  - `oor_addr` captures the data-port address, which has priority.
- Array contents are not reset. They are undefined until written or preloaded by the bench through hierarchical `$readmemh`.

## Timing
- Read latency is exactly 1 cycle: request in cycle N, rdata valid throughout cycle N+1, held until the next read on that port.
- Write takes effect at the edge ending cycle N; a read issued in cycle N+1 sees it.
- Never stalls; the interface has no handshake. Every enabled request is accepted in the cycle it is presented.
- Reset values: `inst_sram_rdata`=0, `data_sram_rdata`=0, `oor_err`=0, `oor_addr`=0, `oor_cnt`=0.
- Reset asserted mid-operation: requests in that cycle are ignored, including writes. Outputs take reset values at that edge.

## Configuration
- `SRAM_OOR_DIAG_EN` defined: diagnostic logic as described.
- `SRAM_OOR_DIAG_EN` undefined:
  - `oor_err`, `oor_addr` and `oor_cnt` are tied to 0 and have no registers.
  - Out-of-range reads still return 0 and writes are still dropped.

## Structure
- Package `sram_pkg`:
  - `SRAM_BASE_DEFAULT` (32'h1C00_0000)
  - `SRAM_OOR_CNT_W` (16)
  - helper function `sram_in_range(addr, base, idx_w)`
- Sub-module `sram_bank`: the storage array with one byte-masked write port and two registered read ports. The read ports are old-data-on-collision.
- `sram_responder` owns address decode, range check, out-of-range read zeroing and diagnostics.

## Test plan
- Store word then load: write 32'hDEADBEEF, `we`=4'hF at 32'h1C00_0010; next cycle read the same address → `data_sram_rdata`=32'hDEADBEEF one cycle later.
- Byte lanes: word holds 32'h11223344; write `we`=4'b0100, `wdata`=32'h00AA0000 → read returns 32'h11AA3344.
- Collision: in one cycle, fetch 32'h1C00_0020 and data-write 32'h55555555 to the same word (old value 32'h0) → `inst_sram_rdata`=0; a fetch next cycle returns 32'h55555555.
- Out of range:
  - Read 32'h0000_0100 → `data_sram_rdata`=0, `oor_err`=1, `oor_addr`=32'h0000_0100, `oor_cnt`=1.
  - A later write to 32'hFFFF_FFF0 is dropped; `oor_cnt`=2 and `oor_addr` is unchanged.
- Dual out of range: both ports out of range in the same cycle → `oor_cnt` +2 and `oor_addr` = data-port address. With the count preset near 16'hFFFF it saturates at 16'hFFFF.
- Reset mid-stream: assert `reset` in the same cycle as a write to 32'h1C00_0000 → rdata outputs and diagnostics are 0 and the word is unchanged.
